// File: rtl/simplebus_mem_responder_if.sv
// SimpleBus request/response channel bundle between a NutCore initiator
// port (master) and a memory responder (slave).
interface simplebus_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  io_req_valid;
  logic                  io_req_ready;
  logic [ADDR_W-1:0]     io_req_bits_addr;
  logic [2:0]            io_req_bits_size;
  logic [3:0]            io_req_bits_cmd;
  logic [DATA_W/8-1:0]   io_req_bits_wmask;
  logic [DATA_W-1:0]     io_req_bits_wdata;
  logic                  io_resp_valid;
  logic                  io_resp_ready;
  logic [3:0]            io_resp_bits_cmd;
  logic [DATA_W-1:0]     io_resp_bits_rdata;

  modport master (
    output io_req_valid, io_req_bits_addr, io_req_bits_size, io_req_bits_cmd,
           io_req_bits_wmask, io_req_bits_wdata, io_resp_ready,
    input  io_req_ready, io_resp_valid, io_resp_bits_cmd, io_resp_bits_rdata
  );

  modport slave (
    input  io_req_valid, io_req_bits_addr, io_req_bits_size, io_req_bits_cmd,
           io_req_bits_wmask, io_req_bits_wdata, io_resp_ready,
    output io_req_ready, io_resp_valid, io_resp_bits_cmd, io_resp_bits_rdata
  );
endinterface

// File: rtl/simplebus_mem_responder.sv
// SimpleBus memory responder: single/burst read and write, probe, with a
// fixed request-to-response latency and fully registered outputs.
module simplebus_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic clock,
  input  logic reset,
  simplebus_mem_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int MW = DATA_W / 8;
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [3:0] CMD_READ       = 4'b0000;
  localparam logic [3:0] CMD_WRITE      = 4'b0001;
  localparam logic [3:0] CMD_READ_BURST = 4'b0010;
  localparam logic [3:0] CMD_WR_BURST   = 4'b0011;
  localparam logic [3:0] CMD_PREFETCH   = 4'b0100;
  localparam logic [3:0] CMD_WRITE_RESP = 4'b0101;
  localparam logic [3:0] CMD_READ_LAST  = 4'b0110;
  localparam logic [3:0] CMD_WRITE_LAST = 4'b0111;
  localparam logic [3:0] CMD_PROBE      = 4'b1000;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RDATA, S_WBURST, S_WRESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [1:0]          beat_q, beat_d;
  logic [IW-1:0]       widx_q, widx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          left_q, left_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [3:0]          resp_cmd_q, resp_cmd_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [IW-1:0]       mem_widx;
  logic [IW-1:0]       rd_idx;

  logic          req_fire, resp_fire;
  logic [IW-1:0] req_idx;
  logic [1:0]    req_beat;

  assign req_fire  = bus.io_req_valid && req_ready_q;
  assign resp_fire = resp_valid_q && bus.io_resp_ready;
  assign req_idx   = bus.io_req_bits_addr[IW+2:3];
  assign req_beat  = bus.io_req_bits_addr[4:3];

  function automatic logic is_read(input logic [3:0] c);
    return (c == CMD_READ) || (c == CMD_PREFETCH) || (c == CMD_READ_BURST);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      beat_q       <= '0;
      widx_q       <= '0;
      cnt_q        <= '0;
      left_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_cmd_q   <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      beat_q       <= beat_d;
      widx_q       <= widx_d;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_cmd_q   <= resp_cmd_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next state plus the bookkeeping that travels with it (index, counters, write strobe).
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    beat_d   = beat_q;
    widx_d   = widx_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    mem_we   = 1'b0;
    mem_widx = req_idx;
    case (state_q)
      S_IDLE: if (req_fire) begin
        cmd_d  = bus.io_req_bits_cmd;
        beat_d = req_beat;
        widx_d = req_idx;
        cnt_d  = CW'(LATENCY);
        left_d = (bus.io_req_bits_cmd == CMD_READ_BURST) ? 3'd4 : 3'd1;
        if (bus.io_req_bits_cmd == CMD_WR_BURST) begin
          mem_we  = 1'b1;
          beat_d  = req_beat + 2'd1;
          state_d = S_WBURST;
        end else begin
          mem_we = (bus.io_req_bits_cmd == CMD_WRITE) ||
                   (bus.io_req_bits_cmd == CMD_WRITE_LAST);
          if (LATENCY == 0)
            state_d = is_read(bus.io_req_bits_cmd) ? S_RDATA : S_WRESP;
          else
            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CW'(1)) state_d = is_read(cmd_q) ? S_RDATA : S_WRESP;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_RDATA: if (resp_fire) begin
        if (left_q == 3'd1) state_d = S_IDLE;
        else begin
          left_d = left_q - 3'd1;
          beat_d = beat_q + 2'd1;
        end
      end
      S_WBURST: if (req_fire) begin
        // Continuation beats ignore their address and land on the wrapped slot.
        mem_we   = 1'b1;
        mem_widx = {widx_q[IW-1:2], beat_q};
        beat_d   = beat_q + 2'd1;
        if (bus.io_req_bits_cmd == CMD_WRITE_LAST) begin
          cmd_d   = CMD_WRITE_LAST;
          cnt_d   = CW'(LATENCY);
          state_d = (LATENCY == 0) ? S_WRESP : S_WAIT;
        end
      end
      S_WRESP: if (resp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_idx = {widx_d[IW-1:2], beat_d};

  // Registered outputs are loaded on entry to a response state or when a read beat retires.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE) || (state_d == S_WBURST);
    resp_valid_d = resp_valid_q;
    resp_cmd_d   = resp_cmd_q;
    resp_rdata_d = resp_rdata_q;
    if (state_d == S_RDATA && (state_q != S_RDATA || resp_fire)) begin
      resp_valid_d = 1'b1;
      resp_cmd_d   = (left_d == 3'd1) ? CMD_READ_LAST : CMD_READ;
      resp_rdata_d = mem[rd_idx];
    end else if (state_d == S_WRESP && state_q != S_WRESP) begin
      resp_valid_d = 1'b1;
      resp_cmd_d   = (cmd_d == CMD_PROBE) ? CMD_PROBE : CMD_WRITE_RESP;
      resp_rdata_d = '0;
    end else if (resp_fire) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < MW; b++)
        if (bus.io_req_bits_wmask[b]) mem[mem_widx][b*8 +: 8] <= bus.io_req_bits_wdata[b*8 +: 8];
    end
  end

  assign bus.io_req_ready       = req_ready_q;
  assign bus.io_resp_valid      = resp_valid_q;
  assign bus.io_resp_bits_cmd   = resp_cmd_q;
  assign bus.io_resp_bits_rdata = resp_rdata_q;

endmodule
